// File: rtl/synth_pkg.sv
// Shared DAC frame constants and the SPI transmit state encoding for the
// synthesizer output path.
package synth_pkg;

  localparam int DAC_FRAME_W = 16;
  localparam int DAC_DATA_W  = 12;

  // Bit positions inside the 4-bit MCP4921 config nibble
  localparam int DAC_CFG_AB_BIT     = 3;
  localparam int DAC_CFG_BUF_BIT    = 2;
  localparam int DAC_CFG_GA_N_BIT   = 1;
  localparam int DAC_CFG_SHDN_N_BIT = 0;

  localparam logic [3:0] DAC_CFG_CH_A_1X = 4'((1 << DAC_CFG_GA_N_BIT) | (1 << DAC_CFG_SHDN_N_BIT));

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    HOLD     = 3'd4,
    LATCH    = 3'd5
  } dac_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV+1 clocks.
module sample_tick_gen #(
  parameter int DIV = 249
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(DIV + 2);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DIV)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == CW'(DIV));

endmodule

// File: rtl/dac_spi_mixer.sv
// Mixes two 11-bit channels into one 12-bit sample per sample tick and ships
// it to an MCP4921-class DAC as a 16-bit SPI write followed by an LDAC pulse.
module dac_spi_mixer
  import synth_pkg::*;
#(
  parameter int         SCLK_DIV   = 3,
  parameter int         SAMPLE_DIV = 249,
  parameter logic [3:0] DAC_CFG    = DAC_CFG_CH_A_1X
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        mute,
  input  logic [10:0] ch_a,
  input  logic [10:0] ch_b,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        dac_ldac_n,
  output logic        busy,
  output logic        overrun
);

  localparam int HW = $clog2(SCLK_DIV + 2);

  if (SAMPLE_DIV + 1 < 35 * (SCLK_DIV + 1)) begin : g_rate_check
    $error("dac_spi_mixer: sample period shorter than one 35-half-period DAC frame");
  end

  function automatic logic [DAC_DATA_W-1:0] mix_sample(input logic [10:0] a,
                                                      input logic [10:0] b,
                                                      input logic        m);
    // Two 11-bit operands cannot exceed 4094, so the 12-bit sum never wraps
    return m ? '0 : ({1'b0, a} + {1'b0, b});
  endfunction

  dac_state_t                 state_q, state_d;
  logic [HW-1:0]              hcnt_q, hcnt_d;
  logic [4:0]                 bit_q, bit_d;
  logic [DAC_FRAME_W-1:0]     frame_p0, frame_d;
  logic                       tick, capture, half_done;
  logic                       cs_n_d, sclk_d, mosi_d, ldac_n_d, busy_d, overrun_d;

  sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign half_done = (hcnt_q == HW'(SCLK_DIV));
  assign frame_d   = capture ? {DAC_CFG, mix_sample(ch_a, ch_b, mute)} : frame_p0;
  assign overrun_d = overrun | (tick && (state_q != IDLE));

  // Next-state: bit_q is the index of the bit currently presented on MOSI
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    capture = 1'b0;
    if (state_q == IDLE) begin
      hcnt_d = '0;
      bit_d  = '0;
      if (tick && ena) begin
        capture = 1'b1;
        state_d = SETUP;
      end
    end else if (half_done) begin
      hcnt_d = '0;
      case (state_q)
        SETUP:    state_d = SHIFT_HI;
        SHIFT_HI: begin
          state_d = SHIFT_LO;
          bit_d   = bit_q + 5'd1;
        end
        SHIFT_LO: state_d = (bit_q == 5'd16) ? HOLD : SHIFT_HI;
        HOLD:     state_d = LATCH;
        default:  state_d = IDLE;
      endcase
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  // Outputs decoded from the next state so the registered pins line up with it
  always_comb begin
    cs_n_d   = 1'b1;
    sclk_d   = 1'b0;
    mosi_d   = 1'b0;
    ldac_n_d = 1'b1;
    busy_d   = (state_d != IDLE);
    case (state_d)
      SETUP, SHIFT_HI, SHIFT_LO: begin
        cs_n_d = 1'b0;
        sclk_d = (state_d == SHIFT_HI);
        mosi_d = bit_d[4] ? 1'b0 : frame_d[~bit_d[3:0]];
      end
      LATCH:   ldac_n_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      bit_q   <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      overrun <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_mosi   <= 1'b0;
      dac_ldac_n <= 1'b1;
      busy       <= 1'b0;
    end else begin
      dac_cs_n   <= cs_n_d;
      dac_sclk   <= sclk_d;
      dac_mosi   <= mosi_d;
      dac_ldac_n <= ldac_n_d;
      busy       <= busy_d;
    end
  end

  // Frame data register: only meaningful while busy, so it carries no reset
  always_ff @(posedge clk) begin
    frame_p0 <= frame_d;
  end

endmodule

// File: tb/tb_dac_spi_mixer.sv
// Scoreboard bench for dac_spi_mixer: expected frames are queued when inputs
// are set up and compared against the words shifted out on the SPI pins.
module tb_dac_spi_mixer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        mute = 1'b0;
  logic [10:0] ch_a = '0;
  logic [10:0] ch_b = '0;

  logic dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n, busy, overrun;
  logic f_cs_n, f_sclk, f_mosi, f_ldac_n, f_busy, f_overrun;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  dac_spi_mixer dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .mute       (mute),
    .ch_a       (ch_a),
    .ch_b       (ch_b),
    .dac_cs_n   (dac_cs_n),
    .dac_sclk   (dac_sclk),
    .dac_mosi   (dac_mosi),
    .dac_ldac_n (dac_ldac_n),
    .busy       (busy),
    .overrun    (overrun)
  );

  dac_spi_mixer #(.SCLK_DIV(3), .SAMPLE_DIV(139)) dut_fast (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .mute       (mute),
    .ch_a       (ch_a),
    .ch_b       (ch_b),
    .dac_cs_n   (f_cs_n),
    .dac_sclk   (f_sclk),
    .dac_mosi   (f_mosi),
    .dac_ldac_n (f_ldac_n),
    .busy       (f_busy),
    .overrun    (f_overrun)
  );

  // Collects one frame from the default instance, sampling on falling clk edges
  task automatic capture(output logic [15:0] data, output int nb, output int cs,
                         output int ld, output int bz, output bit to);
    int   guard;
    logic ps;
    data = '0; nb = 0; cs = 0; ld = 0; bz = 0; to = 1'b0;
    guard = 0;
    ps = 1'b0;
    while (busy !== 1'b1 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 600) begin
      to = 1'b1;
      return;
    end
    guard = 0;
    while (busy === 1'b1 && guard < 1000) begin
      bz++;
      if (dac_cs_n === 1'b0) cs++;
      if (dac_ldac_n === 1'b0) ld++;
      if (dac_sclk === 1'b1 && ps === 1'b0) begin
        data = {data[14:0], dac_mosi};
        nb++;
      end
      ps = dac_sclk;
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) to = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ena = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dac_cs_n !== 1'b1)   begin errors++; $display("FAIL reset_cs_n: got %b want 1", dac_cs_n); end
    checks++; if (dac_sclk !== 1'b0)   begin errors++; $display("FAIL reset_sclk: got %b want 0", dac_sclk); end
    checks++; if (dac_mosi !== 1'b0)   begin errors++; $display("FAIL reset_mosi: got %b want 0", dac_mosi); end
    checks++; if (dac_ldac_n !== 1'b1) begin errors++; $display("FAIL reset_ldac_n: got %b want 1", dac_ldac_n); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    rst = 1'b1;
  endtask

  task automatic test_ena_off();
    int lowcs = 0;
    int bz = 0;
    ena = 1'b0;
    repeat (5 * 250 + 20) begin
      @(negedge clk);
      if (dac_cs_n !== 1'b1) lowcs++;
      if (busy !== 1'b0) bz++;
    end
    checks++; if (lowcs != 0)       begin errors++; $display("FAIL ena_off_cs: %0d low cycles, want 0", lowcs); end
    checks++; if (bz != 0)          begin errors++; $display("FAIL ena_off_busy: %0d busy cycles, want 0", bz); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ena_off_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_basic();
    logic [15:0] d, e;
    int nb, cs, ld, bz;
    bit to;
    ch_a = 11'd1024; ch_b = 11'd512; mute = 1'b0; ena = 1'b1;
    exp_q.push_back(16'h3600);
    capture(d, nb, cs, ld, bz, to);
    e = exp_q.pop_front();
    checks++; if (to)       begin errors++; $display("FAIL basic_timeout: frame did not complete"); end
    checks++; if (d !== e)  begin errors++; $display("FAIL basic_frame: got %h want %h", d, e); end
    checks++; if (nb != 16) begin errors++; $display("FAIL basic_bits: got %0d sclk rises want 16", nb); end
    checks++; if (cs != 132) begin errors++; $display("FAIL basic_cs_low: got %0d want 132", cs); end
    checks++; if (ld != 4)  begin errors++; $display("FAIL basic_ldac_low: got %0d want 4", ld); end
    checks++; if (bz != 140) begin errors++; $display("FAIL basic_busy: got %0d want 140", bz); end
  endtask

  task automatic test_values();
    logic [15:0] d, e;
    int nb, cs, ld, bz;
    bit to;
    ch_a = 11'd2047; ch_b = 11'd2047; mute = 1'b0;
    exp_q.push_back(16'h3FFE);
    capture(d, nb, cs, ld, bz, to);
    e = exp_q.pop_front();
    checks++; if (to || d !== e) begin errors++; $display("FAIL max_sum: got %h want %h (timeout=%0d)", d, e, to); end
    mute = 1'b1;
    exp_q.push_back(16'h3000);
    capture(d, nb, cs, ld, bz, to);
    e = exp_q.pop_front();
    checks++; if (to || d !== e) begin errors++; $display("FAIL mute: got %h want %h (timeout=%0d)", d, e, to); end
    mute = 1'b0;
  endtask

  task automatic test_midframe_change();
    logic [15:0] d, e;
    int nb, cs, ld, bz, guard;
    bit to;
    ch_a = 11'd100; ch_b = 11'd50;
    exp_q.push_back(16'h3096);
    guard = 0;
    while (busy !== 1'b1 && guard < 600) begin @(negedge clk); guard++; end
    fork
      capture(d, nb, cs, ld, bz, to);
      begin
        repeat (20) @(negedge clk);
        ch_a = 11'd2000;
      end
    join
    e = exp_q.pop_front();
    checks++; if (to || d !== e) begin errors++; $display("FAIL inflight_frame: got %h want %h (timeout=%0d)", d, e, to); end
    exp_q.push_back(16'h3802);
    capture(d, nb, cs, ld, bz, to);
    e = exp_q.pop_front();
    checks++; if (to || d !== e) begin errors++; $display("FAIL next_frame: got %h want %h (timeout=%0d)", d, e, to); end
  endtask

  task automatic test_ena_midframe();
    logic [15:0] d, e;
    int nb, cs, ld, bz, guard, extra;
    bit to;
    ch_a = 11'd300; ch_b = 11'd200;
    exp_q.push_back(16'h31F4);
    guard = 0;
    while (busy !== 1'b1 && guard < 600) begin @(negedge clk); guard++; end
    fork
      capture(d, nb, cs, ld, bz, to);
      begin
        repeat (20) @(negedge clk);
        ena = 1'b0;
      end
    join
    e = exp_q.pop_front();
    checks++; if (to || d !== e) begin errors++; $display("FAIL ena_drop_frame: got %h want %h (timeout=%0d)", d, e, to); end
    checks++; if (ld != 4) begin errors++; $display("FAIL ena_drop_ldac: got %0d want 4", ld); end
    extra = 0;
    repeat (600) begin
      @(negedge clk);
      if (busy !== 1'b0 || dac_cs_n !== 1'b1) extra++;
    end
    checks++; if (extra != 0)       begin errors++; $display("FAIL ena_drop_idle: %0d active cycles want 0", extra); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ena_drop_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_overrun_fast();
    logic fb[0:430];
    logic fo[0:430];
    ena = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fb[0] = f_busy; fo[0] = f_overrun;
    for (int n = 1; n <= 430; n++) begin
      @(negedge clk);
      fb[n] = f_busy;
      fo[n] = f_overrun;
    end
    checks++; if (fb[139] !== 1'b0) begin errors++; $display("FAIL fast_pre_start: busy %b want 0", fb[139]); end
    checks++; if (fb[140] !== 1'b1) begin errors++; $display("FAIL fast_start: busy %b want 1", fb[140]); end
    checks++; if (fb[279] !== 1'b1 || fo[279] !== 1'b0) begin errors++; $display("FAIL fast_latch: busy %b overrun %b want 1 0", fb[279], fo[279]); end
    checks++; if (fb[280] !== 1'b0) begin errors++; $display("FAIL fast_drop: busy %b want 0", fb[280]); end
    checks++; if (fo[280] !== 1'b1) begin errors++; $display("FAIL fast_overrun: got %b want 1", fo[280]); end
    checks++; if (fb[419] !== 1'b0 || fb[420] !== 1'b1) begin errors++; $display("FAIL fast_third_tick: busy %b %b want 0 1", fb[419], fb[420]); end
    checks++; if (fo[430] !== 1'b1) begin errors++; $display("FAIL fast_sticky: overrun %b want 1", fo[430]); end
  endtask

  task automatic test_reset_midframe();
    int   guard, rises, n, lowcs;
    logic ps;
    ena = 1'b1;
    guard = 0;
    while (busy !== 1'b1 && guard < 600) begin @(negedge clk); guard++; end
    rises = 0;
    ps = dac_sclk;
    while (rises < 8 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (dac_sclk === 1'b1 && ps === 1'b0) rises++;
      ps = dac_sclk;
    end
    checks++; if (rises != 8) begin errors++; $display("FAIL rst_mid_sclk: saw %0d rises want 8", rises); end
    rst = 1'b0;
    #1;
    checks++; if (dac_cs_n !== 1'b1) begin errors++; $display("FAIL rst_mid_cs_n: got %b want 1", dac_cs_n); end
    checks++; if (dac_sclk !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk_low: got %b want 0", dac_sclk); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    lowcs = 0;
    while (busy !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1 && dac_cs_n !== 1'b1) lowcs++;
    end
    checks++; if (n != 250)   begin errors++; $display("FAIL rst_first_frame: started after %0d cycles want 250", n); end
    checks++; if (lowcs != 0) begin errors++; $display("FAIL rst_quiet: %0d cs_n low cycles want 0", lowcs); end
  endtask

  initial begin
    test_reset();
    test_ena_off();
    test_basic();
    test_values();
    test_midframe_change();
    test_ena_midframe();
    test_overrun_fast();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
